mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the IF stage (fetch) and the MEM
//  stage (load/store) of the 5-stage pipeline CPU. Grants one access at a time and drives the
//  memory through a request/ready handshake, returning data with a one-cycle ack pulse.
//  stall_o freezes PC and IFID_Reg, and holds the pipeline, while any request is outstanding.
// PARAMETERS
//  ADDR_W      32  address width, bytes
//  DATA_W      32  data width
//  STARVE_LIM  4   consecutive DM grants allowed while IF is waiting before IF is forced (>=1)
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       synchronous reset, active-high
//  if_req_i     in   1       fetch request; held high until if_ack_o
//  if_addr_i    in   ADDR_W  fetch address; stable while if_req_i high
//  if_rdata_o   out  DATA_W  fetched instruction; valid in the if_ack_o cycle, held after
//  if_ack_o     out  1       one-cycle completion pulse for fetch
//  dm_req_i     in   1       data request; held high until dm_ack_o
//  dm_we_i      in   1       1 = store, 0 = load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data; valid in the dm_ack_o cycle, held after
//  dm_ack_o     out  1       one-cycle completion pulse for data
//  mem_en_o     out  1       memory access active
//  mem_we_o     out  1       memory write enable (qualified by mem_en_o)
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_rdata_i  in   DATA_W  memory read data; valid when mem_ready_i is high
//  mem_ready_i  in   1       memory completes the current access this cycle
//  stall_o      out  1       (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational
// BEHAVIOUR
//  Reset: state=IDLE; starve_cnt=0; all registered outputs 0 (en, we, addr, wdata, rdata, acks).
//  FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
//  IDLE:
//   - DM wins over IF, unless if_req_i && starve_cnt==STARVE_LIM; then IF wins.
//   - On grant, latch addr/we/wdata into the mem_* registers and go to BUSY_x.
//   - mem_en_o rises in the cycle after the grant edge.
//   - IF grants carry we=0 and wdata=0.
//  starve_cnt:
//   - +1 on a DM grant while if_req_i is high, saturating at STARVE_LIM.
//   - Cleared on an IF grant, or on a DM grant while if_req_i is low.
//  BUSY_x:
//   - mem_en_o=1; mem_* held stable; requests on both ports are ignored.
//   - When mem_ready_i=1: load mem_rdata_i into x_rdata_o (loads and fetches only; stores
//     leave dm_rdata_o unchanged), set x_ack_o=1, go to RESP.
//   - mem_en_o and mem_we_o drop at the same edge.
//  RESP:
//   - Exactly one ack is high, for exactly one cycle. Requests are not sampled. Next state is
//     IDLE.
//   - The requester drops or renews its request after seeing the ack.
//  Latency: a zero-wait-state memory (ready in the first BUSY cycle) gives grant->ack = 2
//   cycles. Minimum spacing of back-to-back accesses is 3 cycles.
//  Boundaries:
//   - mem_ready_i outside BUSY_x is ignored.
//   - Requests arriving during BUSY/RESP wait; they are never lost.
//   - Both requests in IDLE: the priority rule above applies.
//   - A request deasserted before its grant is a protocol violation; behaviour is undefined.
//  Reset mid-access: the next state is IDLE with all outputs 0. The in-flight access is
//   abandoned with no ack, and the memory tolerates mem_en_o dropping.
//  Addresses and data pass through unmodified; no alignment checking.
// TESTING
//  1 Reset: hold rst_i 2 cycles -> all outputs 0, stall_o equals request terms only, no ack.
//  2 IF read: if_addr_i=0x10, ready on 3rd BUSY cycle with 0x8C010004 -> mem_en_o high
//    3 cycles, mem_addr_o=0x10, mem_we_o=0; if_ack_o 1-cycle pulse with rdata 0x8C010004;
//    stall_o high until the ack cycle.
//  3 Collision: IF 0x14 and DM store 0x100/0xDEADBEEF in the same cycle -> DM served first
//    (mem_we_o=1, wdata 0xDEADBEEF), dm_rdata_o unchanged, then IF served, zero-wait grant->ack=2.
//  4 Starvation, STARVE_LIM=4: IF held, DM re-requested every RESP -> 4 DM grants, then IF
//    grant, starve_cnt=0.
//  5 Reset during BUSY_DM with ready held low -> mem_en_o=0 next cycle, no dm_ack_o; a later
//    IF request completes normally.
//  6 mem_ready_i pulses in IDLE and in RESP -> no ack, no state change, rdata registers
//    unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by mem_port_arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the view of the CPU stages plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ready_i,
        output if_rdata_o, if_ack_o,
        output dm_rdata_o, dm_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ready_i,
        input  if_rdata_o, if_ack_o,
        input  dm_rdata_o, dm_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access, with
// DM priority bounded by a starvation counter that eventually forces an IF grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIM);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusyIf = 2'd1,
        StBusyDm = 2'd2,
        StResp   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;

    logic              if_forced;

    // IF only wins a collision once DM has been granted STARVE_LIM times in a row over it.
    assign if_forced = bus.if_req_i && (starve_cnt_q == StarveMax);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.dm_req_i && !if_forced) begin
                    state_d     = StBusyDm;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.dm_we_i;
                    mem_addr_d  = bus.dm_addr_i;
                    mem_wdata_d = bus.dm_wdata_i;
                    if (!bus.if_req_i) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != StarveMax) begin
                        starve_cnt_d = starve_cnt_q + CntW'(1);
                    end
                end else if (bus.if_req_i) begin
                    state_d      = StBusyIf;
                    mem_en_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.if_addr_i;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end
            end

            StBusyIf: begin
                if (bus.mem_ready_i) begin
                    state_d    = StResp;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = bus.mem_rdata_i;
                    if_ack_d   = 1'b1;
                end
            end

            StBusyDm: begin
                if (bus.mem_ready_i) begin
                    state_d  = StResp;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    // Stores complete without disturbing the last load result.
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata_i;
                    end
                    dm_ack_d = 1'b1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
        end
    end

    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.dm_ack_o    = dm_ack_q;

    // Combinational so the pipeline releases in the very cycle the ack is seen.
    assign bus.stall_o = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);

endmodule
